// File: rtl/instruction_encoder.sv
// Encodes a decoded RV64 instruction (branch/JAL/CSR/ECALL/EBREAK subset) into a 32-bit code word.
// Latency: 1 cycle from accept to code_o when the output FIFO is empty; entries stay in order.
// Backpressure: FIFO_DEPTH-entry output buffer; cmd_ready_o drops only when the buffer is full.
//
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   cmd_i / cmd_valid_i / cmd_ready_o      decoded instruction in (valid/ready)
//   code_o / illegal_o / code_valid_o / code_ready_i   encoded word out (FIFO head, valid/ready)

package rv64g_pkg;
    typedef enum logic [4:0] {
        INVALID = 5'd0,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        JAL,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
        ECALL, EBREAK
    } funct_e;

    typedef struct packed {
        funct_e      funct;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [11:0] csr;
        logic [4:0]  uimm;
    } decoded_instr_t;
endpackage

module instruction_encoder
    import rv64g_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  decoded_instr_t cmd_i,
    input  logic           cmd_valid_i,
    output logic           cmd_ready_o,
    output logic [31:0]    code_o,
    output logic           illegal_o,
    output logic           code_valid_o,
    input  logic           code_ready_i
);
    // Pointer width is forced to at least one bit so a depth-1 buffer still elaborates.
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   r_mem_code [FIFO_DEPTH];
    logic          r_mem_ill  [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [31:0]   w_code;
    logic          w_ill;
    logic [2:0]    w_f3;
    logic          w_br_imm_ok;
    logic          w_jal_imm_ok;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;

    // The immediate must fit the instruction's signed field and be halfword aligned.
    assign w_br_imm_ok  = (cmd_i.imm[63:12] == {52{cmd_i.imm[12]}}) && !cmd_i.imm[0];
    assign w_jal_imm_ok = (cmd_i.imm[63:20] == {44{cmd_i.imm[20]}}) && !cmd_i.imm[0];

    always_comb begin
        w_f3   = 3'd0;
        w_code = 32'd0;
        w_ill  = 1'b0;
        case (cmd_i.funct)
            BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
                case (cmd_i.funct)
                    BNE:     w_f3 = 3'd1;
                    BLT:     w_f3 = 3'd4;
                    BGE:     w_f3 = 3'd5;
                    BLTU:    w_f3 = 3'd6;
                    BGEU:    w_f3 = 3'd7;
                    default: w_f3 = 3'd0;
                endcase
                w_ill  = !w_br_imm_ok;
                w_code = {cmd_i.imm[12], cmd_i.imm[10:5], cmd_i.rs2, cmd_i.rs1, w_f3,
                          cmd_i.imm[4:1], cmd_i.imm[11], 7'b1100011};
            end
            JAL: begin
                w_ill  = !w_jal_imm_ok;
                w_code = {cmd_i.imm[20], cmd_i.imm[10:1], cmd_i.imm[11], cmd_i.imm[19:12],
                          cmd_i.rd, 7'b1101111};
            end
            CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI: begin
                case (cmd_i.funct)
                    CSRRW:   w_f3 = 3'd1;
                    CSRRS:   w_f3 = 3'd2;
                    CSRRC:   w_f3 = 3'd3;
                    CSRRWI:  w_f3 = 3'd5;
                    CSRRSI:  w_f3 = 3'd6;
                    default: w_f3 = 3'd7;
                endcase
                // funct3[2] selects the immediate form, which carries uimm in the rs1 slot.
                w_code = {cmd_i.csr, (w_f3[2] ? cmd_i.uimm : cmd_i.rs1), w_f3,
                          cmd_i.rd, 7'b1110011};
            end
            ECALL:   w_code = 32'h0000_0073;
            EBREAK:  w_code = 32'h0010_0073;
            default: w_ill  = 1'b1;
        endcase
        // Rejected entries still flow through the buffer, but with a zero code word.
        if (w_ill) begin
            w_code = 32'd0;
        end
    end

    assign cmd_ready_o  = (r_count != CW'(FIFO_DEPTH));
    assign code_valid_o = (r_count != CW'(0));
    assign code_o       = code_valid_o ? r_mem_code[r_rptr] : 32'd0;
    assign illegal_o    = code_valid_o ? r_mem_ill[r_rptr]  : 1'b0;

    assign w_push     = cmd_valid_i & cmd_ready_o;
    assign w_pop      = code_valid_o & code_ready_i;
    assign w_wptr_nxt = (r_wptr == PW'(FIFO_DEPTH - 1)) ? PW'(0) : r_wptr + PW'(1);
    assign w_rptr_nxt = (r_rptr == PW'(FIFO_DEPTH - 1)) ? PW'(0) : r_rptr + PW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: the pointers and count alone decide what is visible.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_code[r_wptr] <= w_code;
            r_mem_ill[r_wptr]  <= w_ill;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;
    import rv64g_pkg::*;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    decoded_instr_t cmd_i;
    logic           cmd_valid_i;
    logic           cmd_ready_o;
    logic [31:0]    code_o;
    logic           illegal_o;
    logic           code_valid_o;
    logic           code_ready_i;

    instruction_encoder #(.FIFO_DEPTH(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cmd_i        (cmd_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .code_o       (code_o),
        .illegal_o    (illegal_o),
        .code_valid_o (code_valid_o),
        .code_ready_i (code_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    localparam int NRAND = 11000;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic decoded_instr_t mk(input funct_e f, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [63:0] imm, input logic [11:0] csr,
                                          input logic [4:0] uimm);
        decoded_instr_t c;
        c.funct = f; c.rd = rd; c.rs1 = rs1; c.rs2 = rs2;
        c.imm = imm; c.csr = csr; c.uimm = uimm;
        return c;
    endfunction

    // Reference decoder: reads an instruction word back into its fields.
    function automatic decoded_instr_t decode(input logic [31:0] c);
        decoded_instr_t d;
        logic [12:0] bimm;
        logic [20:0] jimm;
        d = '0;
        d.funct = INVALID;
        case (c[6:0])
            7'b1100011: begin
                case (c[14:12])
                    3'd0: d.funct = BEQ;
                    3'd1: d.funct = BNE;
                    3'd4: d.funct = BLT;
                    3'd5: d.funct = BGE;
                    3'd6: d.funct = BLTU;
                    3'd7: d.funct = BGEU;
                    default: d.funct = INVALID;
                endcase
                d.rs1 = c[19:15];
                d.rs2 = c[24:20];
                bimm  = {c[31], c[7], c[30:25], c[11:8], 1'b0};
                d.imm = {{51{bimm[12]}}, bimm};
            end
            7'b1101111: begin
                d.funct = JAL;
                d.rd    = c[11:7];
                jimm    = {c[31], c[19:12], c[20], c[30:21], 1'b0};
                d.imm   = {{43{jimm[20]}}, jimm};
            end
            7'b1110011: begin
                if (c == 32'h0000_0073) d.funct = ECALL;
                else if (c == 32'h0010_0073) d.funct = EBREAK;
                else begin
                    case (c[14:12])
                        3'd1: d.funct = CSRRW;
                        3'd2: d.funct = CSRRS;
                        3'd3: d.funct = CSRRC;
                        3'd5: d.funct = CSRRWI;
                        3'd6: d.funct = CSRRSI;
                        3'd7: d.funct = CSRRCI;
                        default: d.funct = INVALID;
                    endcase
                    d.csr = c[31:20];
                    d.rd  = c[11:7];
                    if (c[14]) d.uimm = c[19:15];
                    else       d.rs1  = c[19:15];
                end
            end
            default: d.funct = INVALID;
        endcase
        return d;
    endfunction

    // Legality from the value ranges of each instruction's immediate.
    function automatic bit is_legal(input decoded_instr_t c);
        longint s;
        s = longint'(c.imm);
        case (c.funct)
            BEQ, BNE, BLT, BGE, BLTU, BGEU:
                return (s >= -4096) && (s <= 4095) && (c.imm[0] == 1'b0);
            JAL:
                return (s >= -1048576) && (s <= 1048575) && (c.imm[0] == 1'b0);
            CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI, ECALL, EBREAK:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    function automatic decoded_instr_t rand_cmd(input bit want_illegal);
        funct_e         flist [15];
        decoded_instr_t c;
        longint         v;
        flist = '{BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, CSRRW, CSRRS, CSRRC,
                  CSRRWI, CSRRSI, CSRRCI, ECALL, EBREAK};
        c = '0;
        c.funct = flist[$urandom_range(0, 14)];
        case (c.funct)
            BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
                c.rs1 = 5'($urandom); c.rs2 = 5'($urandom);
                v = longint'($urandom_range(0, 4095)) * 2 - 4096;
                c.imm = 64'(v);
            end
            JAL: begin
                c.rd = 5'($urandom);
                v = longint'($urandom_range(0, 1048575)) * 2 - 1048576;
                c.imm = 64'(v);
            end
            CSRRW, CSRRS, CSRRC: begin
                c.rd = 5'($urandom); c.rs1 = 5'($urandom); c.csr = 12'($urandom);
            end
            CSRRWI, CSRRSI, CSRRCI: begin
                c.rd = 5'($urandom); c.uimm = 5'($urandom); c.csr = 12'($urandom);
            end
            default: ;
        endcase
        if (want_illegal) begin
            case ($urandom_range(0, 3))
                0: c.funct = INVALID;
                1: begin c.funct = BLT; c.imm = 64'(longint'(4096) + 2 * longint'($urandom_range(0, 1000))); end
                2: begin c.funct = JAL; c.imm = 64'(2 * longint'($urandom_range(0, 1000)) + 1); end
                default: c.funct = funct_e'(5'd31);
            endcase
        end
        return c;
    endfunction

    decoded_instr_t seq_cmd  [5];
    logic [31:0]    seq_code [5];
    logic           seq_ill  [5];

    decoded_instr_t q_cmd [$];
    bit             q_leg [$];
    decoded_instr_t cur_cmd;
    decoded_instr_t exp_cmd;
    bit             exp_leg;
    int             pushed;
    int             cyc;
    bit             stalled;
    logic [31:0]    prev_code;
    logic           prev_ill;

    initial begin
        rst_ni = 1'b0; cmd_i = '0; cmd_valid_i = 1'b0; code_ready_i = 1'b0;

        // Reset state
        step(); step();
        check("rst_cmd_ready", cmd_ready_o, 1'b1);
        check("rst_code_valid", code_valid_o, 1'b0);
        check("rst_code", code_o, 32'd0);
        check("rst_illegal", illegal_o, 1'b0);
        rst_ni = 1'b1;
        step();

        // Single BEQ, one-cycle latency
        cmd_i = mk(BEQ, 5'd0, 5'd1, 5'd2, 64'd8, 12'd0, 5'd0);
        cmd_valid_i = 1'b1;
        step();
        cmd_valid_i = 1'b0;
        check("beq_valid", code_valid_o, 1'b1);
        check("beq_code", code_o, 32'h0020_8463);
        check("beq_illegal", illegal_o, 1'b0);
        code_ready_i = 1'b1;
        step();
        check("beq_popped", code_valid_o, 1'b0);

        // Streaming with ready high: illegal entries stay in order between legal ones,
        // and push+pop at count=1 keeps the buffer at one entry.
        seq_cmd[0] = mk(JAL, 5'd1, 5'd0, 5'd0, 64'h800, 12'd0, 5'd0);
        seq_cmd[1] = mk(BNE, 5'd0, 5'd3, 5'd4, 64'h1000, 12'd0, 5'd0);
        seq_cmd[2] = mk(CSRRWI, 5'd5, 5'd0, 5'd0, 64'd0, 12'h300, 5'd3);
        seq_cmd[3] = mk(INVALID, 5'd7, 5'd7, 5'd7, 64'd4, 12'd0, 5'd0);
        seq_cmd[4] = mk(EBREAK, 5'd0, 5'd0, 5'd0, 64'd0, 12'd0, 5'd0);
        seq_code = '{32'h0010_00EF, 32'd0, 32'h3001_D2F3, 32'd0, 32'h0010_0073};
        seq_ill  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cmd_i = seq_cmd[i];
            cmd_valid_i = 1'b1;
            step();
            check($sformatf("seq%0d_valid", i), code_valid_o, 1'b1);
            check($sformatf("seq%0d_code", i), code_o, seq_code[i]);
            check($sformatf("seq%0d_illegal", i), illegal_o, seq_ill[i]);
            check($sformatf("seq%0d_cmd_ready", i), cmd_ready_o, 1'b1);
        end
        cmd_valid_i = 1'b0;
        step();
        check("seq_drained", code_valid_o, 1'b0);

        // Backpressure: three back-to-back pushes against a stalled consumer
        code_ready_i = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_i = mk(CSRRW, 5'd1, 5'd2, 5'd0, 64'd0, 12'h341, 5'd0);   // 34111 0F3
        step();
        check("bp_ready_after1", cmd_ready_o, 1'b1);
        cmd_i = mk(CSRRS, 5'd3, 5'd4, 5'd0, 64'd0, 12'h342, 5'd0);   // 342221F3
        step();
        check("bp_ready_after2", cmd_ready_o, 1'b0);
        cmd_i = mk(ECALL, 5'd0, 5'd0, 5'd0, 64'd0, 12'd0, 5'd0);
        step();
        check("bp_third_held", cmd_ready_o, 1'b0);
        check("bp_head_stable", code_o, 32'h3411_10F3);
        code_ready_i = 1'b1;
        step();
        check("bp_drain1", code_o, 32'h3422_21F3);
        check("bp_drain1_ready", cmd_ready_o, 1'b1);
        step();
        cmd_valid_i = 1'b0;
        check("bp_drain2", code_o, 32'h0000_0073);
        check("bp_drain2_valid", code_valid_o, 1'b1);
        step();
        check("bp_empty", code_valid_o, 1'b0);

        // Reset with two buffered entries
        code_ready_i = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_i = seq_cmd[0];
        step();
        cmd_i = seq_cmd[2];
        step();
        cmd_valid_i = 1'b0;
        check("mrst_full", cmd_ready_o, 1'b0);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check("mrst_valid", code_valid_o, 1'b0);
        check("mrst_ready", cmd_ready_o, 1'b1);
        check("mrst_code", code_o, 32'd0);
        code_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mrst_no_stale%0d", i), code_valid_o, 1'b0);
        end

        // Random round trip with valid/ready gaps
        pushed  = 0;
        cyc     = 0;
        stalled = 1'b0;
        cur_cmd = rand_cmd($urandom_range(0, 11) == 0);
        while ((pushed < NRAND || q_cmd.size() != 0) && cyc < 60000) begin
            @(negedge clk_i);
            cmd_i        = cur_cmd;
            cmd_valid_i  = (pushed < NRAND) && ($urandom_range(0, 3) != 0);
            code_ready_i = (pushed >= NRAND) || ($urandom_range(0, 3) != 0);
            #1;
            if (stalled) begin
                check("rand_hold_code", {code_valid_o, illegal_o, code_o}, {1'b1, prev_ill, prev_code});
            end
            if (code_valid_o && code_ready_i) begin
                if (q_cmd.size() == 0) begin
                    check("rand_spurious", code_valid_o, 1'b0);
                end else begin
                    exp_cmd = q_cmd.pop_front();
                    exp_leg = q_leg.pop_front();
                    if (exp_leg) begin
                        check("rand_illegal_flag", illegal_o, 1'b0);
                        check("rand_roundtrip", 128'(decode(code_o)), 128'(exp_cmd));
                    end else begin
                        check("rand_illegal_flag", illegal_o, 1'b1);
                        check("rand_illegal_code", code_o, 32'd0);
                    end
                end
            end
            stalled   = code_valid_o && !code_ready_i;
            prev_code = code_o;
            prev_ill  = illegal_o;
            if (cmd_valid_i && cmd_ready_o) begin
                q_cmd.push_back(cur_cmd);
                q_leg.push_back(is_legal(cur_cmd));
                pushed++;
                cur_cmd = rand_cmd($urandom_range(0, 11) == 0);
            end
            cyc++;
        end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        check("rand_all_pushed", pushed, NRAND);
        check("rand_all_drained", q_cmd.size(), 0);
        #1;
        check("rand_final_empty", code_valid_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
